// File: rtl/mcu_pkg.sv
// Shared definitions for the 16-bit MCU pipeline: opcode field layout and fetch FSM states.
package mcu_pkg;

  localparam logic [3:0] OPC_HALT = 4'hF;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  function automatic logic is_halt(input logic [3:0] opc);
    return opc == OPC_HALT;
  endfunction

endpackage

// File: rtl/mcu_fetch_unit.sv
// Instruction fetch: owns the PC, drives a synchronous-read ROM and hands one
// instruction per cycle to decode under a valid/stall handshake.
module mcu_fetch_unit
  import mcu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               halted
);

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;

  logic run;
  logic advance;
  logic halt_acc;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pend_d        = pend_q;
    pend_pc_d     = pend_pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;

    run      = (state_q == RUN);
    advance  = run && !(instr_valid_q && stall);
    halt_acc = run && instr_valid_q && !stall && is_halt(instr_q[OPC_MSB:OPC_LSB]);

    // When not advancing, replay the held address so the ROM output stays aligned with pend_pc.
    if (run && branch_valid) begin
      imem_addr = branch_target;
    end else if (advance) begin
      imem_addr = fetch_pc_q;
    end else begin
      imem_addr = pend_pc_q;
    end

    if (run) begin
      if (branch_valid) begin
        pend_d        = 1'b1;
        pend_pc_d     = branch_target;
        fetch_pc_d    = branch_target + PC_ONE;
        instr_valid_d = 1'b0;
      end else if (halt_acc) begin
        state_d       = HALTED;
        halted_d      = 1'b1;
        instr_valid_d = 1'b0;
        pend_d        = 1'b0;
      end else if (advance) begin
        instr_d       = imem_rdata;
        pc_out_d      = pend_pc_q;
        instr_valid_d = pend_q;
        pend_pc_d     = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_ONE;
        pend_d        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      pend_q        <= 1'b0;
      pend_pc_q     <= '0;
      instr_q       <= '0;
      pc_out_q      <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pend_q        <= pend_d;
      pend_pc_q     <= pend_pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_mcu_fetch_unit.sv
// Scoreboard bench for mcu_fetch_unit: linear run, stall, branch, halt, branch-vs-halt,
// reset override, plus a 4-bit-PC instance for wrap-around.
module tb_mcu_fetch_unit;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        branch_valid = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [7:0]  pc_out;
  logic        halted;

  logic [3:0]  w_addr;
  logic [15:0] w_rdata;
  logic        w_branch;
  logic [3:0]  w_target;
  logic        w_stall;
  logic        w_valid;
  logic [15:0] w_instr;
  logic [3:0]  w_pc;
  logic        w_halted;

  logic [15:0] rom   [256];
  logic [15:0] rom_w [16];

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wraps = 0;
  logic [3:0] exp_w = 4'h0;

  logic chk_rst = 0, chk_hold = 0, chk_halt = 0, chk_nohalt = 0;
  logic chk_invalid = 0, chk_empty = 0, chk_wrap = 0, tmo_req = 0;
  logic [7:0]  hold_pc = 8'h00;
  logic [15:0] hold_ins = 16'h0000;

  assign w_branch = 1'b0;
  assign w_target = 4'h0;
  assign w_stall  = 1'b0;

  always #5 clk = ~clk;

  mcu_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .branch_valid(branch_valid), .branch_target(branch_target), .stall(stall),
    .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out), .halted(halted)
  );

  mcu_fetch_unit #(.ADDR_W(4), .INSTR_W(16), .RESET_PC(4'h0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .branch_valid(w_branch), .branch_target(w_target), .stall(w_stall),
    .instr_valid(w_valid), .instr(w_instr), .pc_out(w_pc), .halted(w_halted)
  );

  always @(posedge clk) imem_rdata <= rom[imem_addr];
  always @(posedge clk) w_rdata <= rom_w[w_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always begin
    @(negedge clk);
    if (tmo_req)     check("timeout", 32'd1, 32'd0);
    if (chk_rst) begin
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_pc", {24'd0, pc_out}, 32'd0);
      check("rst_instr", {16'd0, instr}, 32'd0);
      check("rst_w_valid", {31'd0, w_valid}, 32'd0);
    end
    if (chk_hold) begin
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_pc", {24'd0, pc_out}, {24'd0, hold_pc});
      check("hold_instr", {16'd0, instr}, {16'd0, hold_ins});
    end
    if (chk_halt) begin
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_valid", {31'd0, instr_valid}, 32'd0);
    end
    if (chk_nohalt)  check("nohalt_flag", {31'd0, halted}, 32'd0);
    if (chk_invalid) check("bubble_valid", {31'd0, instr_valid}, 32'd0);
    if (chk_empty)   check("sb_leftover", sb_q.size(), 32'd0);
    if (chk_wrap)    check("wrap_seen", {31'd0, (wraps > 0)}, 32'd1);

    if (rst_n === 1'b1 && instr_valid === 1'b1 && stall === 1'b0 && branch_valid === 1'b0) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", {24'd0, pc_out}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pc", {24'd0, pc_out}, {24'd0, e.pc});
        check("sb_instr", {16'd0, instr}, {16'd0, e.ins});
      end
    end

    if (rst_n === 1'b0) begin
      exp_w = 4'h0;
    end else if (w_valid === 1'b1) begin
      check("wrap_pc", {28'd0, w_pc}, {28'd0, exp_w});
      check("wrap_instr", {16'd0, w_instr}, {12'h100, exp_w});
      if (w_pc == 4'hF) wraps++;
      exp_w = exp_w + 4'h1;
    end
  end

  task automatic push(input logic [7:0] pc, input logic [15:0] ins);
    exp_t e;
    e.pc  = pc;
    e.ins = ins;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flag_timeout();
    tmo_req = 1'b1;
    cyc();
    tmo_req = 1'b0;
  endtask

  task automatic wait_pc(input logic [7:0] pc);
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (instr_valid === 1'b1 && pc_out == pc) return;
    end
    flag_timeout();
  endtask

  task automatic wait_halted();
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (halted === 1'b1) return;
    end
    flag_timeout();
  endtask

  // Reset with a branch request pending: reset must override it.
  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    branch_valid = 1'b1;
    branch_target = 8'h55;
    cyc();
    chk_rst = 1'b1;
    cyc();
    chk_rst = 1'b0;
    branch_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic check_empty();
    chk_empty = 1'b1;
    cyc();
    chk_empty = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 16; i++)  rom_w[i] = 16'h1000 + 16'(i);

    // Linear run, stall at pc 4, branch to 0x40, then branch to 0x80 under stall
    for (int i = 0; i <= 5; i++) push(8'(i), 16'h1000 + 16'(i));
    for (int i = 8'h40; i <= 8'h44; i++) push(8'(i), 16'h1000 + 16'(i));
    push(8'h80, 16'h1080);
    push(8'h81, 16'h1081);
    push(8'h82, 16'h1082);
    do_reset();

    wait_pc(8'h04);
    stall = 1'b1;
    hold_pc = 8'h04;
    hold_ins = 16'h1004;
    chk_hold = 1'b1;
    repeat (3) cyc();
    chk_hold = 1'b0;
    stall = 1'b0;

    wait_pc(8'h06);
    branch_valid = 1'b1;
    branch_target = 8'h40;
    cyc();
    branch_valid = 1'b0;
    chk_invalid = 1'b1;
    cyc();
    chk_invalid = 1'b0;

    wait_pc(8'h45);
    stall = 1'b1;
    branch_valid = 1'b1;
    branch_target = 8'h80;
    cyc();
    branch_valid = 1'b0;
    stall = 1'b0;
    chk_invalid = 1'b1;
    cyc();
    chk_invalid = 1'b0;
    wait_pc(8'h83);
    stall = 1'b1;
    check_empty();

    // Halt: HALT word delivered once, then absorbing despite branch/stall activity
    rst_n = 1'b0;
    rom[3] = 16'hF000;
    push(8'h00, 16'h1000);
    push(8'h01, 16'h1001);
    push(8'h02, 16'h1002);
    push(8'h03, 16'hF000);
    do_reset();
    wait_halted();
    chk_halt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      branch_valid = i[0];
      branch_target = 8'h10;
      stall = i[1];
      cyc();
    end
    branch_valid = 1'b0;
    stall = 1'b0;
    cyc();
    chk_halt = 1'b0;
    check_empty();

    // Branch coinciding with HALT acceptance: branch wins
    push(8'h00, 16'h1000);
    push(8'h01, 16'h1001);
    push(8'h02, 16'h1002);
    push(8'h20, 16'h1020);
    push(8'h21, 16'h1021);
    do_reset();
    wait_pc(8'h03);
    branch_valid = 1'b1;
    branch_target = 8'h20;
    cyc();
    branch_valid = 1'b0;
    chk_nohalt = 1'b1;
    wait_pc(8'h22);
    stall = 1'b1;
    cyc();
    chk_nohalt = 1'b0;
    check_empty();

    // Mid-stream reset while running, then restart from RESET_PC
    push(8'h00, 16'h1000);
    push(8'h01, 16'h1001);
    do_reset();
    wait_pc(8'h02);
    stall = 1'b1;
    check_empty();
    chk_wrap = 1'b1;
    cyc();
    chk_wrap = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
